output_error_stage: RTL and testbench

Output stage of the bitnet datapath; sits directly downstream of the last perceptron layer. It takes a target label per sample and waits a fixed settle time for the combinational majority-gate network to resolve. It then samples the forward outputs and emits the target and mismatch mask as backward-pass bits for the perceptrons' `bin*` inputs. It also keeps saturating sample and error statistics.

---
 rtl/bitnet_pkg.sv | 17 +
 rtl/output_error_stage_if.sv | 26 ++
 rtl/output_error_stage_sat_counter.sv | 28 ++
 rtl/output_error_stage.sv | 92 +++++++++
 tb/tb_output_error_stage.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/bitnet_pkg.sv
// Shared types and constants for the bitnet datapath output/error stage.
package bitnet_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        EMIT
    } oes_state_t;

    localparam int SETTLE_W = 8;

    // Counter preload so that fwd is captured exactly `cycles` edges after accept.
    function automatic logic [SETTLE_W-1:0] settle_load(input int cycles);
        return SETTLE_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/output_error_stage_if.sv
// Label-in / backward-bits-out handshake bundle of the output error stage.
interface output_error_stage_if #(
    parameter int N_OUT = 3
);
    import bitnet_pkg::*;

    logic             sample_valid_in;
    logic             sample_ready_out;
    logic [N_OUT-1:0] target_in;
    logic [N_OUT-1:0] fwd_in;
    logic             bwd_valid_out;
    logic             bwd_ready_in;
    logic [N_OUT-1:0] bwd_out;
    logic [N_OUT-1:0] err_mask_out;

    modport master (
        output sample_valid_in, target_in, fwd_in, bwd_ready_in,
        input  sample_ready_out, bwd_valid_out, bwd_out, err_mask_out
    );

    modport slave (
        input  sample_valid_in, target_in, fwd_in, bwd_ready_in,
        output sample_ready_out, bwd_valid_out, bwd_out, err_mask_out
    );

endinterface

// File: rtl/output_error_stage_sat_counter.sv
// Saturating up-counter with a synchronous clear that overrides increment.
module sat_counter
    import bitnet_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (inc && (count_reg != '1)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/output_error_stage.sv
// Output stage: waits for the forward network to settle, then emits target
// and error mask as backward bits while keeping saturating statistics.
module output_error_stage
    import bitnet_pkg::*;
#(
    parameter int N_OUT         = 3,
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 16
) (
    input  logic               clk_in,
    input  logic               rst_in,
    output_error_stage_if.slave bus,
    input  logic               clear_stats_in,
    output logic [CNT_W-1:0]   sample_count_out,
    output logic [CNT_W-1:0]   error_count_out,
    output logic               busy_out
);

    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = settle_load(SETTLE_CYCLES);

    oes_state_t          state_reg;
    logic [SETTLE_W-1:0] settle_reg;
    logic [N_OUT-1:0]    target_reg;
    logic [N_OUT-1:0]    bwd_reg;
    logic [N_OUT-1:0]    mask_reg;
    logic [N_OUT-1:0]    mask_next;
    logic                handshake;

    for (genvar gi = 0; gi < N_OUT; gi++) begin : g_mask
        assign mask_next[gi] = bus.fwd_in[gi] ^ target_reg[gi];
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_reg  <= IDLE;
            settle_reg <= '0;
            target_reg <= '0;
            bwd_reg    <= '0;
            mask_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.sample_valid_in) begin
                        target_reg <= bus.target_in;
                        settle_reg <= SETTLE_LOAD;
                        state_reg  <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (settle_reg != '0) begin
                        settle_reg <= settle_reg - 1'b1;
                    end else begin
                        // Only edge where fwd_in is trusted to have resolved.
                        bwd_reg   <= target_reg;
                        mask_reg  <= mask_next;
                        state_reg <= EMIT;
                    end
                end
                EMIT: begin
                    if (bus.bwd_ready_in) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign handshake            = (state_reg == EMIT) && bus.bwd_ready_in;
    assign bus.sample_ready_out = (state_reg == IDLE);
    assign bus.bwd_valid_out    = (state_reg == EMIT);
    assign bus.bwd_out          = bwd_reg;
    assign bus.err_mask_out     = mask_reg;
    assign busy_out             = (state_reg != IDLE);

    sat_counter #(.W(CNT_W)) u_sample_cnt (
        .clk   (clk_in),
        .rst   (rst_in),
        .inc   (handshake),
        .clr   (clear_stats_in),
        .count (sample_count_out)
    );

    sat_counter #(.W(CNT_W)) u_error_cnt (
        .clk   (clk_in),
        .rst   (rst_in),
        .inc   (handshake && (mask_reg != '0)),
        .clr   (clear_stats_in),
        .count (error_count_out)
    );

endmodule

// File: tb/tb_output_error_stage.sv
// Directed bench for output_error_stage (N_OUT=3, SETTLE_CYCLES=4, CNT_W=4).
module tb_output_error_stage;
    import bitnet_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clear_stats = 1'b0;
    logic [3:0] sample_count;
    logic [3:0] error_count;
    logic       busy;

    int n_cmp = 0;
    int n_mis = 0;

    output_error_stage_if #(.N_OUT(3)) bus ();

    output_error_stage #(
        .N_OUT         (3),
        .SETTLE_CYCLES (4),
        .CNT_W         (4)
    ) dut (
        .clk_in           (clk),
        .rst_in           (rst),
        .bus              (bus.slave),
        .clear_stats_in   (clear_stats),
        .sample_count_out (sample_count),
        .error_count_out  (error_count),
        .busy_out         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Presents a label and returns at the falling edge after the accept edge.
    task automatic accept(input logic [2:0] tgt, input logic [2:0] fwd, input logic rdy);
        int waited = 0;
        @(negedge clk);
        bus.target_in       = tgt;
        bus.fwd_in          = fwd;
        bus.bwd_ready_in    = rdy;
        bus.sample_valid_in = 1'b1;
        while (!bus.sample_ready_out && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.sample_ready_out) check("accept_timeout", 16'(bus.sample_ready_out), 16'd1);
        @(posedge clk);
        @(negedge clk);
        bus.sample_valid_in = 1'b0;
    endtask

    // Returns at the first falling edge where bwd_valid_out is high.
    task automatic wait_valid();
        int waited = 0;
        while (!bus.bwd_valid_out && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.bwd_valid_out) check("valid_timeout", 16'(bus.bwd_valid_out), 16'd1);
    endtask

    initial begin
        bus.sample_valid_in = 1'b0;
        bus.target_in       = 3'b000;
        bus.fwd_in          = 3'b000;
        bus.bwd_ready_in    = 1'b0;

        // Reset values, before and after clocks run.
        #1;
        check("rst_ready", 16'(bus.sample_ready_out), 16'd1);
        check("rst_valid", 16'(bus.bwd_valid_out), 16'd0);
        check("rst_busy", 16'(busy), 16'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_bwd", 16'(bus.bwd_out), 16'd0);
        check("rst_mask", 16'(bus.err_mask_out), 16'd0);
        check("rst_scnt", 16'(sample_count), 16'd0);
        check("rst_ecnt", 16'(error_count), 16'd0);

        // Matching sample: exact latency of bwd_valid_out.
        accept(3'b101, 3'b101, 1'b1);
        check("t1_busy", 16'(busy), 16'd1);
        check("t1_ready_low", 16'(bus.sample_ready_out), 16'd0);
        check("t1_valid_T", 16'(bus.bwd_valid_out), 16'd0);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            check($sformatf("t1_valid_T+%0d", i), 16'(bus.bwd_valid_out), 16'd0);
        end
        @(negedge clk);
        check("t1_valid_T+4", 16'(bus.bwd_valid_out), 16'd1);
        check("t1_bwd", 16'(bus.bwd_out), 16'b101);
        check("t1_mask", 16'(bus.err_mask_out), 16'b000);
        @(negedge clk);
        check("t1_valid_done", 16'(bus.bwd_valid_out), 16'd0);
        check("t1_ready_back", 16'(bus.sample_ready_out), 16'd1);
        check("t1_scnt", 16'(sample_count), 16'd1);
        check("t1_ecnt", 16'(error_count), 16'd0);
        check("t1_bwd_hold", 16'(bus.bwd_out), 16'b101);

        // fwd_in changes only just before the capture edge, and after it.
        accept(3'b110, 3'b000, 1'b1);
        repeat (3) @(negedge clk);
        bus.fwd_in = 3'b010;
        @(negedge clk);
        check("t2_valid", 16'(bus.bwd_valid_out), 16'd1);
        check("t2_mask", 16'(bus.err_mask_out), 16'b100);
        check("t2_bwd", 16'(bus.bwd_out), 16'b110);
        bus.fwd_in = 3'b111;
        @(negedge clk);
        check("t2_valid_done", 16'(bus.bwd_valid_out), 16'd0);
        check("t2_mask_hold", 16'(bus.err_mask_out), 16'b100);
        check("t2_scnt", 16'(sample_count), 16'd2);
        check("t2_ecnt", 16'(error_count), 16'd1);

        // Backpressure in EMIT.
        accept(3'b011, 3'b001, 1'b0);
        wait_valid();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("t3_valid_%0d", i), 16'(bus.bwd_valid_out), 16'd1);
            check($sformatf("t3_bwd_%0d", i), 16'(bus.bwd_out), 16'b011);
            check($sformatf("t3_mask_%0d", i), 16'(bus.err_mask_out), 16'b010);
            check($sformatf("t3_ready_%0d", i), 16'(bus.sample_ready_out), 16'd0);
            check($sformatf("t3_scnt_%0d", i), 16'(sample_count), 16'd2);
            check($sformatf("t3_ecnt_%0d", i), 16'(error_count), 16'd1);
        end
        bus.bwd_ready_in = 1'b1;
        @(negedge clk);
        check("t3_valid_done", 16'(bus.bwd_valid_out), 16'd0);
        check("t3_scnt", 16'(sample_count), 16'd3);
        check("t3_ecnt", 16'(error_count), 16'd2);

        // Saturation at 15 with 20 mismatching samples.
        for (int i = 0; i < 20; i++) begin
            accept(3'b111, 3'b000, 1'b1);
            wait_valid();
            @(negedge clk);
            if (i == 11) begin
                check("t4_scnt_mid", 16'(sample_count), 16'd15);
                check("t4_ecnt_mid", 16'(error_count), 16'd14);
            end
        end
        check("t4_scnt_sat", 16'(sample_count), 16'd15);
        check("t4_ecnt_sat", 16'(error_count), 16'd15);

        // Clear coincident with the EMIT handshake.
        accept(3'b111, 3'b000, 1'b1);
        wait_valid();
        clear_stats = 1'b1;
        @(negedge clk);
        clear_stats = 1'b0;
        check("t5_scnt", 16'(sample_count), 16'd0);
        check("t5_ecnt", 16'(error_count), 16'd0);
        check("t5_ready", 16'(bus.sample_ready_out), 16'd1);
        check("t5_busy", 16'(busy), 16'd0);
        check("t5_mask", 16'(bus.err_mask_out), 16'b111);

        // Asynchronous reset in the middle of SETTLE.
        accept(3'b101, 3'b000, 1'b1);
        wait_valid();
        @(negedge clk);
        check("t6_scnt_pre", 16'(sample_count), 16'd1);
        check("t6_ecnt_pre", 16'(error_count), 16'd1);
        accept(3'b010, 3'b010, 1'b1);
        @(negedge clk);
        check("t6_busy_pre", 16'(busy), 16'd1);
        #2;
        rst = 1'b1;
        #1;
        check("t6_busy", 16'(busy), 16'd0);
        check("t6_ready", 16'(bus.sample_ready_out), 16'd1);
        check("t6_valid", 16'(bus.bwd_valid_out), 16'd0);
        check("t6_bwd", 16'(bus.bwd_out), 16'd0);
        check("t6_mask", 16'(bus.err_mask_out), 16'd0);
        check("t6_scnt", 16'(sample_count), 16'd0);
        check("t6_ecnt", 16'(error_count), 16'd0);
        @(negedge clk);
        rst = 1'b0;
        accept(3'b001, 3'b001, 1'b1);
        wait_valid();
        check("t6_bwd_new", 16'(bus.bwd_out), 16'b001);
        check("t6_mask_new", 16'(bus.err_mask_out), 16'b000);
        @(negedge clk);
        check("t6_scnt_new", 16'(sample_count), 16'd1);
        check("t6_ecnt_new", 16'(error_count), 16'd0);
        check("t6_ready_new", 16'(bus.sample_ready_out), 16'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
